instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
Write-side counterpart of the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words to consecutive instruction-memory addresses starting at 0. It holds the CPU in reset while loading, which replaces the simulation-only file preload with a synthesizable boot path (UART/host front-end → loader → instruction memory write port).

Parameters:
ADDR_W, 8, instruction-memory address width (depth 2^ADDR_W = 256 words)
DATA_W, 32, instruction word width; fixed at 4 bytes per word

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE or DONE
word_count  input  ADDR_W+1  number of words to load; latched on accepted start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
words_written  output  ADDR_W+1  words committed in the current/last load
busy  output  1  load in progress
cpu_hold  output  1  hold CPU in reset; equals busy
done  output  1  level; last load completed; cleared by an accepted start

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - state=IDLE.
  - byte_ready, mem_we, busy, cpu_hold and done = 0.
  - mem_addr, mem_wdata and words_written = 0.
  - Byte index = 0; partial word discarded.
- Reset mid-load aborts immediately. Words already written stay in memory.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE/DONE, start=1 at an edge:
  - Latch the count as min(word_count, 256).
  - Clear words_written, mem_addr, the byte index and done.
  - If the count is 0: go to DONE with done=1 on the next cycle and no writes.
  - Otherwise: go to COLLECT.
- start in COLLECT/WRITE is ignored.
- COLLECT:
  - byte_ready=1; busy=cpu_hold=1.
  - A byte transfers on an edge where byte_valid && byte_ready.
  - Byte k (k=0..3) is placed big-endian: byte 0 → [31:24], byte 3 → [7:0].
  - byte_valid while byte_ready=0 has no effect and is not counted.
  - Accepting byte 3 moves the block to WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0 and mem_we=1, with mem_addr and mem_wdata stable for that cycle.
  - On the closing edge, words_written increments and the byte index clears.
  - If words_written+1 equals the count: go to DONE.
  - Otherwise: mem_addr increments and the block returns to COLLECT.
- Latency: if byte 3 is accepted at edge N, mem_we is high between edges N and N+1, and the memory commits at edge N+1. Sustained throughput is 1 word per 5 cycles.
- mem_we is 0 in every state other than WRITE. mem_wdata holds its last value when mem_we is 0.
- DONE: done=1, busy=cpu_hold=0, byte_ready=0. mem_addr holds the last written address.
- Address never wraps. At count 256 the final write is to address 255, then the block goes to DONE.
- Bytes presented after DONE are not accepted (byte_ready=0).

Test Plan:
1. Reset, then start with word_count=2 and bytes 8'h20,8'h08,8'h00,8'h05, 8'h01,8'h09,8'h50,8'h20 with byte_valid held high:
   - mem_we pulses twice: addr 0 = 32'h20080005, addr 1 = 32'h01095020.
   - done=1, words_written=2, cpu_hold falls.
2. Randomly gap byte_valid (idle cycles between bytes) for word_count=1, bytes AA,BB,CC,DD:
   - Single write 32'hAABBCCDD at addr 0.
   - No extra mem_we.
   - byte_ready=0 during the WRITE cycle.
3. start with word_count=0 → done=1 the next cycle, no mem_we, busy never asserted.
4. word_count=300 with 1024 bytes streamed → exactly 256 writes to addresses 0..255, words_written=256, no write to address 0 after 255.
5. Load word_count=3 and assert reset after 6 accepted bytes:
   - One write occurs (addr 0).
   - The next cycle all outputs are 0 and state is IDLE.
   - A new start with word_count=1 writes to addr 0.
6. Pulse start while in COLLECT → ignored: count, address and words_written unchanged. A start in DONE clears done and restarts at addr 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot-time loader: assembles big-endian 32-bit words from a byte stream and
// writes them to consecutive instruction-memory addresses while holding the CPU.
module instr_mem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] MaxCount = CntW'(2 ** ADDR_W);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   ww_q, ww_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            ww_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ww_q    <= ww_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ww_d    = ww_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    count_d = (word_count > MaxCount) ? MaxCount : word_count;
                    ww_d    = '0;
                    addr_d  = '0;
                    idx_d   = '0;
                    state_d = (word_count == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (byte_valid) begin
                    shift_d = {shift_q[DATA_W-9:0], byte_in};
                    idx_d   = idx_q + 2'd1;
                    // Output register only updates on a full word so mem_wdata stays stable.
                    if (idx_q == 2'd3) begin
                        wdata_d = {shift_q[DATA_W-9:0], byte_in};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                ww_d  = ww_q + CntW'(1);
                idx_d = '0;
                if (ww_q + CntW'(1) == count_q) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_ready    = (state_q == StCollect);
    assign mem_we        = (state_q == StWrite);
    assign busy          = (state_q == StCollect) || (state_q == StWrite);
    assign cpu_hold      = busy;
    assign done          = (state_q == StDone);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign words_written = ww_q;

endmodule
